// File: rtl/instmem_fetch_buf.sv
// instmem_fetch_buf: instruction memory with valid/ready fetch port, 2-entry response buffer and load port
module instmem_fetch_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 128,
  parameter int BYTE_ADDR = 1,
  parameter string INIT_FILE = "",
  parameter logic [DATA_W-1:0] NOP_INST = '0,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              resp_fault,
  input  logic              ld_en,
  input  logic [IW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [31:0]       fetch_cnt
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [1:0]        cnt;
  logic              wp, rp;
  logic [DATA_W-1:0] qi [2];
  logic [ADDR_W-1:0] qa [2];
  logic [1:0]        qf;
  logic [ADDR_W-1:0] widx;
  logic              bad, push, pop;
  logic [DATA_W-1:0] rd;
  assign widx = BYTE_ADDR != 0 ? pc >> 2 : pc;
  assign bad = (BYTE_ADDR != 0 && pc[1:0] != 2'b00) || widx >= ADDR_W'(DEPTH);
  assign rd = bad ? NOP_INST : mem[widx[IW-1:0]];
  assign req_ready = !rst && !ld_en && cnt != 2'd2;
  assign resp_valid = cnt != 2'd0;
  assign push = req_valid && req_ready;
  assign pop = resp_valid && resp_ready;
  always_ff @(posedge clk)
    if (ld_en && int'(ld_addr) < DEPTH) mem[ld_addr] <= ld_data;
  always_ff @(posedge clk)
    if (push) begin
      qi[wp] <= rd;
      qa[wp] <= pc;
      qf[wp] <= bad;
    end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      inst <= '0;
      inst_addr <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop && cnt == 2'd2) begin
        inst <= qi[~rp];
        inst_addr <= qa[~rp];
        resp_fault <= qf[~rp];
      end else if (push && (cnt == 2'd0 || pop)) begin
        inst <= rd;
        inst_addr <= pc;
        resp_fault <= bad;
      end
    end
  always_ff @(posedge clk)
    if (rst) fetch_cnt <= '0;
    else if (push && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
endmodule

// File: tb/tb_instmem_fetch_buf.sv
// tb_instmem_fetch_buf: directed self-checking bench for instmem_fetch_buf
module tb_instmem_fetch_buf;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002, WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hD0D0_0004, WE = 32'hE0E0_0005, W5 = 32'h5555_0005;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, resp_valid, resp_ready = 0, resp_fault, ld_en = 0;
  logic [31:0] pc = 0, inst, inst_addr, ld_data = 0, fetch_cnt;
  logic [6:0] ld_addr = 0;
  logic b_req_valid = 0, b_req_ready, b_resp_valid, b_resp_ready = 1, b_resp_fault, b_ld_en = 0;
  logic [31:0] b_pc = 0, b_inst, b_inst_addr, b_ld_data = 0, b_fetch_cnt;
  logic [3:0] b_ld_addr = 0;
  int checks = 0, failures = 0;
  logic [31:0] words [4];
  always #5 clk = ~clk;
  instmem_fetch_buf #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .pc(pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .inst(inst), .inst_addr(inst_addr),
    .resp_fault(resp_fault), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .fetch_cnt(fetch_cnt));
  instmem_fetch_buf #(.DEPTH(16), .BYTE_ADDR(0)) u2 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .pc(b_pc),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .inst(b_inst), .inst_addr(b_inst_addr),
    .resp_fault(b_resp_fault), .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .fetch_cnt(b_fetch_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    words[0] = WA; words[1] = WB; words[2] = WC; words[3] = WD;
    step();
    step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_addr", inst_addr, 32'd0);
    chk("rst_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      ld_en = 1; ld_addr = 7'(i); ld_data = words[i];
      #1 chk("ld_blocks_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    ld_en = 0;
    resp_ready = 1; req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      step();
      chk("b2b_valid", {31'b0, resp_valid}, 32'd1);
      chk("b2b_inst", inst, words[i]);
      chk("b2b_addr", inst_addr, 32'(i * 4));
      chk("b2b_fault", {31'b0, resp_fault}, 32'd0);
    end
    req_valid = 0;
    step();
    chk("drain_valid", {31'b0, resp_valid}, 32'd0);
    chk("drain_hold_inst", inst, WD);
    chk("b2b_fetch_cnt", fetch_cnt, 32'd4);
    resp_ready = 0; req_valid = 1; pc = 0;
    step();
    pc = 4;
    step();
    pc = 8;
    #1 chk("bp_full_ready", {31'b0, req_ready}, 32'd0);
    step();
    chk("bp_head_inst", inst, WA);
    chk("bp_head_addr", inst_addr, 32'd0);
    chk("bp_fetch_cnt", fetch_cnt, 32'd6);
    resp_ready = 1;
    #1 chk("bp_ready_ignores_resp_ready", {31'b0, req_ready}, 32'd0);
    step();
    chk("bp_pop1_inst", inst, WB);
    chk("bp_pop1_addr", inst_addr, 32'd4);
    step();
    chk("bp_pop2_inst", inst, WC);
    chk("bp_pop2_addr", inst_addr, 32'd8);
    chk("bp_fetch_cnt2", fetch_cnt, 32'd7);
    req_valid = 0;
    step();
    chk("bp_drained", {31'b0, resp_valid}, 32'd0);
    req_valid = 1; pc = 2;
    step();
    chk("mis_fault", {31'b0, resp_fault}, 32'd1);
    chk("mis_inst", inst, NOP);
    chk("mis_addr", inst_addr, 32'd2);
    pc = 512;
    step();
    chk("oor_fault", {31'b0, resp_fault}, 32'd1);
    chk("oor_inst", inst, NOP);
    chk("oor_addr", inst_addr, 32'd512);
    pc = 0;
    step();
    chk("after_fault_inst", inst, WA);
    chk("after_fault_fault", {31'b0, resp_fault}, 32'd0);
    req_valid = 0;
    step();
    chk("fault_fetch_cnt", fetch_cnt, 32'd10);
    resp_ready = 0; req_valid = 1; pc = 4;
    step();
    ld_en = 1; ld_addr = 7'd1; ld_data = WE;
    #1 chk("conflict_ready", {31'b0, req_ready}, 32'd0);
    step();
    ld_en = 0;
    chk("conflict_no_accept", fetch_cnt, 32'd11);
    step();
    chk("old_word_kept", inst, WB);
    resp_ready = 1; req_valid = 0;
    step();
    chk("new_word_inst", inst, WE);
    chk("new_word_addr", inst_addr, 32'd4);
    step();
    resp_ready = 0; req_valid = 1; pc = 0;
    step();
    pc = 8;
    step();
    chk("pre_rst_valid", {31'b0, resp_valid}, 32'd1);
    rst = 1;
    #1 chk("rst_cycle_ready", {31'b0, req_ready}, 32'd0);
    step();
    rst = 0; req_valid = 0;
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    resp_ready = 1; req_valid = 1; pc = 4;
    step();
    chk("mem_kept_1", inst, WE);
    pc = 12;
    step();
    chk("mem_kept_3", inst, WD);
    req_valid = 0;
    step();
    b_ld_en = 1; b_ld_addr = 4'd5; b_ld_data = W5;
    step();
    b_ld_en = 0; b_req_valid = 1; b_pc = 5;
    step();
    chk("w_inst", b_inst, W5);
    chk("w_fault", {31'b0, b_resp_fault}, 32'd0);
    b_pc = 16;
    step();
    chk("w_oor_fault", {31'b0, b_resp_fault}, 32'd1);
    chk("w_oor_inst", b_inst, 32'd0);
    chk("w_fetch_cnt", b_fetch_cnt, 32'd2);
    b_req_valid = 0;
    force u2.fetch_cnt = 32'hFFFF_FFFE;
    #1 release u2.fetch_cnt;
    b_req_valid = 1; b_pc = 5;
    step();
    chk("sat_reach", b_fetch_cnt, 32'hFFFF_FFFF);
    step();
    chk("sat_hold", b_fetch_cnt, 32'hFFFF_FFFF);
    b_req_valid = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
